time_counter: RTL and testbench

- Downstream timekeeping stage for the stopwatch/clock datapath.
- Loads a preset ms/sec/min/hr value from the user-entry stage, then advances it by one millisecond per prescaled tick with cascaded carries.
- Drives the display path with a registered, always-legal time value and run status.
- Single clock domain; asynchronous active-low reset.

---
 rtl/time_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 37 +++
 rtl/time_counter.sv | 172 +++++++++++++++++
 tb/tb_time_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared widths, limits, state encoding and time payload for the timekeeping datapath.
package time_pkg;

    localparam int unsigned MS_W    = 10;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HR_W    = 5;

    localparam int unsigned MS_MAX  = 999;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } time_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DIV while enabled; tick_c is high on the terminal count cycle.
module tick_prescaler #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = en && !clr && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// ms/sec/min/hr timekeeper with preset load and cascaded carries.
// Define TIME_COUNTER_COUNTDOWN_EN to add count_down/done and the EXPIRED state.
module time_counter
    import time_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned HR_MAX  = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [MS_W-1:0]  ms_i,
    input  logic [SEC_W-1:0] sec_i,
    input  logic [MIN_W-1:0] min_i,
    input  logic [HR_W-1:0]  hr_i,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
`ifdef TIME_COUNTER_COUNTDOWN_EN
    input  logic             count_down,
    output logic             done,
`endif
    output logic [MS_W-1:0]  ms_o,
    output logic [SEC_W-1:0] sec_o,
    output logic [MIN_W-1:0] min_o,
    output logic [HR_W-1:0]  hr_o,
    output logic             running,
    output logic             rollover
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    localparam logic [MS_W-1:0]  MS_LIM  = MS_W'(MS_MAX);
    localparam logic [SEC_W-1:0] SEC_LIM = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LIM = MIN_W'(MIN_MAX);
    localparam logic [HR_W-1:0]  HR_LIM  = HR_W'(HR_MAX);

    state_e state_q, state_d;
    time_t  t_q, t_d;
    logic   running_q, running_d;
    logic   rollover_q, rollover_d;
    logic   done_q, done_d;
    logic   presc_en, presc_clr, tick;

    // Any control that pre-empts counting also freezes the sub-ms phase this cycle.
    assign presc_en  = (state_q == RUNNING) && !clear && !load && !stop;
    assign presc_clr = clear || load;

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (presc_en),
        .clr    (presc_clr),
        .tick_c (tick)
    );

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        rollover_d = 1'b0;
        done_d     = 1'b0;

        if (clear) begin
            t_d     = '0;
            state_d = STOPPED;
        end else if (load) begin
            t_d.ms  = (ms_i  > MS_LIM)  ? MS_LIM  : ms_i;
            t_d.sec = (sec_i > SEC_LIM) ? SEC_LIM : sec_i;
            t_d.min = (min_i > MIN_LIM) ? MIN_LIM : min_i;
            t_d.hr  = (hr_i  > HR_LIM)  ? HR_LIM  : hr_i;
            state_d = STOPPED;
        end else if (stop) begin
            if (state_q == RUNNING) begin
                state_d = STOPPED;
            end
        end else if (start && (state_q == STOPPED)) begin
`ifdef TIME_COUNTER_COUNTDOWN_EN
            if (count_down && (t_q == '0)) begin
                state_d = EXPIRED;
                done_d  = 1'b1;
            end else begin
                state_d = RUNNING;
            end
`else
            state_d = RUNNING;
`endif
        end else if (tick) begin
`ifdef TIME_COUNTER_COUNTDOWN_EN
            if (count_down) begin
                // Borrow cascade; zero is terminal rather than wrapping.
                if (t_q == '0) begin
                    state_d = EXPIRED;
                    done_d  = 1'b1;
                end else if (t_q.ms != '0) begin
                    t_d.ms = t_q.ms - MS_W'(1);
                end else begin
                    t_d.ms = MS_LIM;
                    if (t_q.sec != '0) begin
                        t_d.sec = t_q.sec - SEC_W'(1);
                    end else begin
                        t_d.sec = SEC_LIM;
                        if (t_q.min != '0) begin
                            t_d.min = t_q.min - MIN_W'(1);
                        end else begin
                            t_d.min = MIN_LIM;
                            t_d.hr  = t_q.hr - HR_W'(1);
                        end
                    end
                end
            end else
`endif
            begin
                if (t_q.ms != MS_LIM) begin
                    t_d.ms = t_q.ms + MS_W'(1);
                end else begin
                    t_d.ms = '0;
                    if (t_q.sec != SEC_LIM) begin
                        t_d.sec = t_q.sec + SEC_W'(1);
                    end else begin
                        t_d.sec = '0;
                        if (t_q.min != MIN_LIM) begin
                            t_d.min = t_q.min + MIN_W'(1);
                        end else begin
                            t_d.min = '0;
                            if (t_q.hr != HR_LIM) begin
                                t_d.hr = t_q.hr + HR_W'(1);
                            end else begin
                                t_d.hr     = '0;
                                rollover_d = 1'b1;
                            end
                        end
                    end
                end
            end
        end

        running_d = (state_d == RUNNING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STOPPED;
            t_q        <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
            done_q     <= done_d;
        end
    end

    assign ms_o     = t_q.ms;
    assign sec_o    = t_q.sec;
    assign min_o    = t_q.min;
    assign hr_o     = t_q.hr;
    assign running  = running_q;
    assign rollover = rollover_q;
`ifdef TIME_COUNTER_COUNTDOWN_EN
    assign done     = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with CLK_HZ=4, TICK_HZ=1 (one tick per 4 clocks).
module tb_time_counter;

    logic       clk;
    logic       rst_n;
    logic       load, start, stop, clear;
    logic [9:0] ms_i;
    logic [5:0] sec_i, min_i;
    logic [4:0] hr_i;
    logic [9:0] ms_o;
    logic [5:0] sec_o, min_o;
    logic [4:0] hr_o;
    logic       running, rollover;
`ifdef TIME_COUNTER_COUNTDOWN_EN
    logic       count_down;
    logic       done;
`endif

    int errors = 0;
    int checks = 0;

    time_counter #(
        .CLK_HZ  (4),
        .TICK_HZ (1),
        .HR_MAX  (23)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .ms_i       (ms_i),
        .sec_i      (sec_i),
        .min_i      (min_i),
        .hr_i       (hr_i),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
`ifdef TIME_COUNTER_COUNTDOWN_EN
        .count_down (count_down),
        .done       (done),
`endif
        .ms_o       (ms_o),
        .sec_o      (sec_o),
        .min_o      (min_o),
        .hr_o       (hr_o),
        .running    (running),
        .rollover   (rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ms;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
        logic [9:0] ems;
        logic [5:0] esec;
        logic [5:0] emin;
        logic [4:0] ehr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_t(input string name, input int hr, input int mn, input int sc, input int ms);
        checks++;
        if ({hr_o, min_o, sec_o, ms_o} !== {5'(hr), 6'(mn), 6'(sc), 10'(ms)}) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d expected %0d:%0d:%0d.%0d",
                     name, hr_o, min_o, sec_o, ms_o, hr, mn, sc, ms);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic s, input logic p, input logic c);
        load = l; start = s; stop = p; clear = c;
        step(1);
        load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic load_time(input int hr, input int mn, input int sc, input int ms);
        hr_i = 5'(hr); min_i = 6'(mn); sec_i = 6'(sc); ms_i = 10'(ms);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{10'd1023, 6'd63, 6'd60, 5'd31, 10'd999, 6'd59, 6'd59, 5'd23};
        vecs[1] = '{10'd0,    6'd0,  6'd0,  5'd0,  10'd0,   6'd0,  6'd0,  5'd0};
        vecs[2] = '{10'd999,  6'd59, 6'd59, 5'd23, 10'd999, 6'd59, 6'd59, 5'd23};
        vecs[3] = '{10'd1000, 6'd60, 6'd0,  5'd24, 10'd999, 6'd59, 6'd0,  5'd23};
        vecs[4] = '{10'd500,  6'd30, 6'd15, 5'd12, 10'd500, 6'd30, 6'd15, 5'd12};
        vecs[5] = '{10'd998,  6'd58, 6'd61, 5'd22, 10'd998, 6'd58, 6'd59, 5'd22};

        rst_n = 1'b0;
        load = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        ms_i = '0; sec_i = '0; min_i = '0; hr_i = '0;
`ifdef TIME_COUNTER_COUNTDOWN_EN
        count_down = 1'b0;
`endif
        step(2);
        chk_t("reset_time", 0, 0, 0, 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_rollover", 32'(rollover), 0);
        rst_n = 1'b1;
        step(1);

        // Load saturation table
        for (int i = 0; i < 6; i++) begin
            hr_i = vecs[i].hr; min_i = vecs[i].min; sec_i = vecs[i].sec; ms_i = vecs[i].ms;
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
            chk_t($sformatf("load_vec%0d", i), int'(vecs[i].ehr), int'(vecs[i].emin),
                  int'(vecs[i].esec), int'(vecs[i].ems));
            chk($sformatf("load_vec%0d_running", i), 32'(running), 0);
        end

        // Carry chain and full wrap
        load_time(23, 59, 59, 998);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_running_start", 32'(running), 1);
        step(3);
        chk_t("wrap_pre_tick", 23, 59, 59, 998);
        step(1);
        chk_t("wrap_first_tick", 23, 59, 59, 999);
        chk("wrap_no_roll_early", 32'(rollover), 0);
        step(3);
        chk("wrap_no_roll_pre", 32'(rollover), 0);
        step(1);
        chk_t("wrap_zero", 0, 0, 0, 0);
        chk("wrap_rollover", 32'(rollover), 1);
        chk("wrap_running", 32'(running), 1);
        step(1);
        chk("wrap_rollover_one_cycle", 32'(rollover), 0);
        chk("wrap_still_running", 32'(running), 1);
        step(3);
        chk_t("wrap_continues", 0, 0, 0, 1);

        // Stop keeps the prescaler phase
        load_time(0, 0, 0, 100);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step(2);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("stop_running", 32'(running), 0);
        step(10);
        chk_t("stop_hold", 0, 0, 0, 100);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_running", 32'(running), 1);
        step(1);
        chk_t("resume_before_tick", 0, 0, 0, 100);
        step(1);
        chk_t("resume_phase_tick", 0, 0, 0, 101);

        // Priority: clear beats load and start
        load_time(5, 10, 20, 300);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        hr_i = 5'd7; min_i = 6'd7; sec_i = 6'd7; ms_i = 10'd7;
        pulse(1'b1, 1'b1, 1'b0, 1'b1);
        chk_t("prio_clear_time", 0, 0, 0, 0);
        chk("prio_clear_running", 32'(running), 0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prio_stop_over_start", 32'(running), 0);
        step(5);
        chk_t("prio_no_count", 0, 0, 0, 0);

        // Asynchronous reset mid-count
        load_time(1, 2, 3, 4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_t("async_rst_time", 0, 0, 0, 0);
        chk("async_rst_running", 32'(running), 0);
        step(1);
        rst_n = 1'b1;
        step(5);
        chk_t("async_rst_stays_stopped", 0, 0, 0, 0);

`ifdef TIME_COUNTER_COUNTDOWN_EN
        // Countdown to expiry
        count_down = 1'b1;
        load_time(0, 0, 0, 2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        step(4);
        chk_t("cd_first", 0, 0, 0, 1);
        step(4);
        chk_t("cd_zero", 0, 0, 0, 0);
        chk("cd_zero_running", 32'(running), 1);
        chk("cd_zero_no_done", 32'(done), 0);
        step(4);
        chk("cd_done", 32'(done), 1);
        chk("cd_expired_running", 32'(running), 0);
        chk("cd_no_rollover", 32'(rollover), 0);
        step(1);
        chk("cd_done_one_cycle", 32'(done), 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cd_start_ignored", 32'(running), 0);
        chk("cd_start_no_done", 32'(done), 0);
        step(4);
        chk_t("cd_hold_zero", 0, 0, 0, 0);
        load_time(0, 0, 1, 0);
        chk_t("cd_load_exit", 0, 0, 1, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cd_restart_running", 32'(running), 1);
        step(4);
        chk_t("cd_borrow", 0, 0, 0, 999);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cd_start_at_zero_done", 32'(done), 1);
        chk("cd_start_at_zero_running", 32'(running), 0);
        count_down = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
